test_monitor: RTL and testbench

TEST_MONITOR -- requirements
Module: test_monitor

---
 rtl/test_monitor.sv | 133 +++++++++++++
 tb/tb_test_monitor.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/test_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : test_monitor
//  Brief    : Sequences a batch of tests (hold in reset, release, watch the
//             per-test fail/finish flags) and records PASS / FAIL / TIMEOUT
//             together with sticky flag masks, first failing index and the
//             number of RUN cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module test_monitor #(
   parameter int NUM_TESTS      = 6,
   parameter int START_DELAY    = 16,
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int COUNT_WIDTH    = 16,
   localparam int IDX_W         = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   start,
   input  logic [NUM_TESTS-1:0]   fail,
   input  logic [NUM_TESTS-1:0]   finish,
   output logic                   test_reset,
   output logic                   done,
   output logic                   pass,
   output logic                   timeout,
   output logic [NUM_TESTS-1:0]   fail_mask,
   output logic [NUM_TESTS-1:0]   finish_mask,
   output logic [IDX_W-1:0]       first_fail_idx,
   output logic [COUNT_WIDTH-1:0] cycles
);

   // Delay counter only needs to hold START_DELAY down to 1.
   localparam int DLY_W = $clog2(START_DELAY + 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_WAIT    = 3'd1,
      S_RUN     = 3'd2,
      S_PASS    = 3'd3,
      S_FAIL    = 3'd4,
      S_TIMEOUT = 3'd5
   } state_t;

   state_t                 state;
   state_t                 state_nxt;
   logic [DLY_W-1:0]       delay_cnt;
   logic [COUNT_WIDTH-1:0] cycles_inc;
   logic [IDX_W-1:0]       fail_low;
   logic                   fail_any;
   logic                   finish_all;
   logic                   hit_timeout;
   logic                   run_entry;

   // RUN-cycle qualifiers; all exit decisions look at this cycle's inputs.
   assign fail_any    = |fail;
   assign finish_all  = &(finish_mask | finish);
   assign cycles_inc  = (&cycles) ? cycles : cycles + 1'b1;
   assign hit_timeout = (cycles_inc == COUNT_WIDTH'(TIMEOUT_CYCLES));
   // A fresh run starts whenever WAIT is entered from a non-WAIT state.
   assign run_entry   = (state_nxt == S_WAIT) && (state != S_WAIT);

   // Lowest set fail bit wins when several tests fail together.
   always_comb begin
      fail_low = '0;
      for (int i = NUM_TESTS - 1; i >= 0; i--) begin
         if (fail[i]) fail_low = IDX_W'(i);
      end
   end

   // Next-state logic with FAIL > PASS > TIMEOUT exit priority from RUN.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:    if (start) state_nxt = S_WAIT;
         S_WAIT:    if (delay_cnt <= DLY_W'(1)) state_nxt = S_RUN;
         S_RUN: begin
            if (fail_any)         state_nxt = S_FAIL;
            else if (finish_all)  state_nxt = S_PASS;
            else if (hit_timeout) state_nxt = S_TIMEOUT;
         end
         S_PASS, S_FAIL, S_TIMEOUT: if (start) state_nxt = S_WAIT;
         default:   state_nxt = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clock) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Registered outputs, delay counter and run bookkeeping.
   always_ff @(posedge clock) begin
      if (!reset) begin
         test_reset     <= 1'b1;
         done           <= 1'b0;
         pass           <= 1'b0;
         timeout        <= 1'b0;
         fail_mask      <= '0;
         finish_mask    <= '0;
         first_fail_idx <= '0;
         cycles         <= '0;
         delay_cnt      <= '0;
      end else begin
         // Status flags follow the state being entered so they line up with it.
         test_reset <= (state_nxt != S_RUN);
         done       <= (state_nxt == S_PASS) || (state_nxt == S_FAIL) ||
                       (state_nxt == S_TIMEOUT);
         pass       <= (state_nxt == S_PASS);
         timeout    <= (state_nxt == S_TIMEOUT);

         if (run_entry) begin
            delay_cnt   <= DLY_W'(START_DELAY);
            fail_mask   <= '0;
            finish_mask <= '0;
            cycles      <= '0;
         end else if (state == S_WAIT) begin
            delay_cnt <= delay_cnt - 1'b1;
         end else if (state == S_RUN) begin
            // Exit cycle included: masks and count reflect the terminating cycle.
            fail_mask   <= fail_mask | fail;
            finish_mask <= finish_mask | finish;
            cycles      <= cycles_inc;
         end

         // Index is captured on entry to FAIL, held there, zero elsewhere.
         if ((state == S_RUN) && (state_nxt == S_FAIL)) first_fail_idx <= fail_low;
         else if (state_nxt != S_FAIL)                  first_fail_idx <= '0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_test_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_test_monitor
//  Brief    : Self-checking bench for test_monitor: directed scenarios plus
//             randomized runs compared with an outcome-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_test_monitor;

   localparam int NT = 4;
   localparam int SD = 3;
   localparam int TO = 20;
   localparam int CW = 8;
   localparam int IW = 2;
   localparam int MAXK = 32;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic [NT-1:0] fail = '0;
   logic [NT-1:0] finish = '0;
   logic          test_reset;
   logic          done;
   logic          pass;
   logic          timeout;
   logic [NT-1:0] fail_mask;
   logic [NT-1:0] finish_mask;
   logic [IW-1:0] first_fail_idx;
   logic [CW-1:0] cycles;

   test_monitor #(
      .NUM_TESTS      (NT),
      .START_DELAY    (SD),
      .TIMEOUT_CYCLES (TO),
      .COUNT_WIDTH    (CW)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .start          (start),
      .fail           (fail),
      .finish         (finish),
      .test_reset     (test_reset),
      .done           (done),
      .pass           (pass),
      .timeout        (timeout),
      .fail_mask      (fail_mask),
      .finish_mask    (finish_mask),
      .first_fail_idx (first_fail_idx),
      .cycles         (cycles)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;

   // Per-RUN-cycle stimulus schedule (index = RUN cycle number, from 1).
   logic [NT-1:0] fs [1:MAXK];
   logic [NT-1:0] ns [1:MAXK];

   // Predicted outcome: kind 0=PASS, 1=FAIL, 2=TIMEOUT.
   int            e_end;
   int            e_kind;
   int            e_idx;
   logic [NT-1:0] e_fm;
   logic [NT-1:0] e_nm;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Packs every output into one word for whole-status comparisons.
   function automatic logic [31:0] status_now();
      return 32'({test_reset, done, pass, timeout, fail_mask, finish_mask, cycles, first_fail_idx});
   endfunction

   function automatic logic [31:0] status_exp(input logic tr, input logic dn, input logic ps,
                                              input logic tm, input logic [NT-1:0] fm,
                                              input logic [NT-1:0] nm, input int cyc, input int idx);
      return 32'({tr, dn, ps, tm, fm, nm, CW'(cyc), IW'(idx)});
   endfunction

   // Outcome of a run decided directly from the rules: first cycle with any
   // fail wins, else first cycle where every test has finished, else TO.
   task automatic predict();
      e_fm = '0; e_nm = '0; e_kind = 2; e_end = TO; e_idx = 0;
      for (int k = 1; k <= TO; k++) begin
         e_fm |= fs[k];
         e_nm |= ns[k];
         if (fs[k] != 0) begin
            e_kind = 1; e_end = k;
            for (int i = NT - 1; i >= 0; i--) if (fs[k][i]) e_idx = i;
            return;
         end
         if (e_nm == {NT{1'b1}}) begin
            e_kind = 0; e_end = k;
            return;
         end
      end
   endtask

   task automatic clear_sched();
      for (int k = 1; k <= MAXK; k++) begin
         fs[k] = '0;
         ns[k] = '0;
      end
   endtask

   task automatic check_terminal(input string name);
      check_eq($sformatf("%s_done", name), 32'(done), 1);
      check_eq($sformatf("%s_pass", name), 32'(pass), 32'(e_kind == 0));
      check_eq($sformatf("%s_timeout", name), 32'(timeout), 32'(e_kind == 2));
      check_eq($sformatf("%s_test_reset", name), 32'(test_reset), 1);
      check_eq($sformatf("%s_cycles", name), 32'(cycles), 32'(e_end));
      check_eq($sformatf("%s_fail_mask", name), 32'(fail_mask), 32'(e_fm));
      check_eq($sformatf("%s_finish_mask", name), 32'(finish_mask), 32'(e_nm));
      check_eq($sformatf("%s_first_fail_idx", name), 32'(first_fail_idx),
               (e_kind == 1) ? 32'(e_idx) : 32'd0);
   endtask

   // One complete run: starts from IDLE or a terminal state at a negedge.
   task automatic run_one(input string name);
      logic [NT-1:0] fm;
      logic [NT-1:0] nm;
      predict();
      start = 1'b1; fail = NT'($urandom); finish = NT'($urandom);
      @(negedge clock);
      for (int w = 1; w <= SD; w++) begin
         check_eq($sformatf("%s_wait%0d", name, w), status_now(),
                  status_exp(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 0, 0));
         start = 1'($urandom); fail = NT'($urandom); finish = NT'($urandom);
         @(negedge clock);
      end
      fm = '0; nm = '0;
      for (int k = 1; k <= e_end; k++) begin
         check_eq($sformatf("%s_run%0d", name, k), status_now(),
                  status_exp(1'b0, 1'b0, 1'b0, 1'b0, fm, nm, k - 1, 0));
         start = 1'($urandom); fail = fs[k]; finish = ns[k];
         fm |= fs[k]; nm |= ns[k];
         @(negedge clock);
      end
      check_terminal(name);
      repeat ($urandom_range(1, 3)) begin
         start = 1'b0; fail = NT'($urandom); finish = NT'($urandom);
         @(negedge clock);
         check_terminal({name, "_hold"});
      end
      fail = '0; finish = '0;
   endtask

   // Reset asserted on RUN cycle 4 while a PASS and a FAIL would also fire.
   task automatic reset_mid_run();
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      repeat (SD) @(negedge clock);
      for (int k = 1; k <= 3; k++) begin
         check_eq($sformatf("rst_mid_run%0d", k), 32'(test_reset), 0);
         finish = (k == 1) ? NT'(1) : '0;
         @(negedge clock);
      end
      reset = 1'b0; start = 1'b1; fail = NT'(4'b0100); finish = NT'(4'hE);
      @(negedge clock);
      check_eq("rst_mid_status", status_now(),
               status_exp(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 0, 0));
      reset = 1'b1; start = 1'b0; fail = '0; finish = '0;
      @(negedge clock);
      check_eq("rst_mid_idle", status_now(),
               status_exp(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 0, 0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int mode;
      reset = 1'b0; start = 1'b1; fail = '1; finish = '1;
      repeat (3) @(negedge clock);
      check_eq("reset_status", status_now(),
               status_exp(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 0, 0));
      reset = 1'b1; start = 1'b0; fail = '0; finish = '0;
      @(negedge clock);
      check_eq("idle_no_start", status_now(),
               status_exp(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 0, 0));

      clear_sched();
      ns[2] = 4'b0001; ns[4] = 4'b0010; ns[5] = 4'b0100; ns[7] = 4'b1000;
      run_one("pass_case");

      clear_sched();
      fs[5] = 4'b0100;
      run_one("fail_case_restart");

      clear_sched();
      fs[3] = 4'b1010; ns[3] = 4'hF;
      run_one("simultaneous");

      clear_sched();
      run_one("timeout_case");

      reset_mid_run();
      clear_sched();
      ns[1] = 4'b0011; ns[2] = 4'b1100;
      run_one("after_reset");

      for (int r = 0; r < 25; r++) begin
         clear_sched();
         mode = $urandom_range(0, 2);
         for (int k = 1; k <= MAXK; k++) begin
            fs[k] = ($urandom_range(0, 24) == 0) ? NT'($urandom_range(1, 15)) : '0;
            case (mode)
               0: ns[k] = ($urandom_range(0, 5) == 0) ? NT'(1 << $urandom_range(0, NT - 1)) : '0;
               1: ns[k] = NT'($urandom) & NT'($urandom);
               default: ns[k] = '0;
            endcase
         end
         run_one($sformatf("rand%0d", r));
      end

      $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
